// File: rtl/sdram_init_checker.sv
// Passive SDRAM power-up sequence monitor: checks PRE / AR / LMR ordering and NOP gaps
// at the pins, captures the mode register and latches the first violation code.
module sdram_init_checker #(
    parameter int INIT_WAIT_CLK = 10000,
    parameter int TRP_CLK       = 2,
    parameter int TRFC_CLK      = 7,
    parameter int TMRD_CLK      = 2,
    parameter int AR_TIMES      = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  cmd_in,
    input  logic [1:0]  ba_in,
    input  logic [12:0] addr_in,
    output logic        init_done,
    output logic [12:0] mode_reg,
    output logic [2:0]  cas_latency,
    output logic [2:0]  burst_len,
    output logic        err,
    output logic [2:0]  err_code
);

    // state    | meaning
    // CHK_WAIT | power-up wait, expecting PRECHARGE-all
    // CHK_TRP  | after PRECHARGE, expecting first AUTO_REFRESH
    // CHK_TRFC | refresh phase, expecting more ARs or the LMR
    // CHK_TMRD | after LMR, waiting out tMRD
    // CHK_DONE | sequence legal; only tracks later LMRs
    // CHK_FAIL | violation latched until reset
    typedef enum logic [2:0] {
        CHK_WAIT, CHK_TRP, CHK_TRFC, CHK_TMRD, CHK_DONE, CHK_FAIL
    } chk_state_t;

    localparam logic [15:0] L_INIT = 16'(INIT_WAIT_CLK);
    localparam logic [15:0] L_TRP  = 16'(TRP_CLK);
    localparam logic [15:0] L_TRFC = 16'(TRFC_CLK);
    localparam logic [15:0] L_TMRD = 16'(TMRD_CLK);
    localparam logic [2:0]  L_AR   = 3'(AR_TIMES);

    chk_state_t  r_state;
    logic [15:0] r_gap;
    logic [2:0]  r_ar_cnt;

    logic        w_nop, w_pre, w_ar, w_lmr;
    logic        w_cl_ok, w_bl_ok, w_legal;
    logic [15:0] w_gap_inc, w_limit;
    logic [2:0]  w_tcode, w_code;
    logic        w_unused;

    // bank address plays no part in any check
    assign w_unused = ^ba_in;

    assign w_nop = cmd_in[3] | (cmd_in[2:0] == 3'b111);
    assign w_pre = (cmd_in == 4'b0010);
    assign w_ar  = (cmd_in == 4'b0001);
    assign w_lmr = (cmd_in == 4'b0000);

    assign w_cl_ok = (addr_in[6:4] == 3'd2) | (addr_in[6:4] == 3'd3);
    assign w_bl_ok = (addr_in[2] == 1'b0) | (addr_in[2:0] == 3'b111);

    assign w_gap_inc = (r_gap == 16'hFFFF) ? r_gap : r_gap + 16'd1;

    always_comb begin
        w_limit = '0;
        w_tcode = 3'd0;
        w_legal = 1'b0;
        case (r_state)
            CHK_WAIT: begin
                w_limit = L_INIT;
                w_tcode = 3'd1;
                w_legal = w_pre;
            end
            CHK_TRP: begin
                w_limit = L_TRP;
                w_tcode = 3'd3;
                w_legal = w_ar;
            end
            CHK_TRFC: begin
                w_limit = L_TRFC;
                w_tcode = 3'd4;
                w_legal = (w_ar & (r_ar_cnt < L_AR)) | (w_lmr & (r_ar_cnt == L_AR));
            end
            CHK_TMRD: begin
                w_limit = L_TMRD;
                w_tcode = 3'd5;
            end
            default: ;
        endcase
    end

    // violation priority: timing, then non-all-bank PRE, then bad mode fields, then ordering
    always_comb begin
        w_code = 3'd0;
        if (r_gap < w_limit)
            w_code = w_tcode;
        else if (w_pre && !addr_in[10])
            w_code = 3'd6;
        else if (w_lmr && !(w_cl_ok && w_bl_ok))
            w_code = 3'd7;
        else if (!w_legal)
            w_code = 3'd2;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= CHK_WAIT;
            r_gap       <= '0;
            r_ar_cnt    <= '0;
            init_done   <= 1'b0;
            mode_reg    <= '0;
            cas_latency <= '0;
            burst_len   <= '0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            r_gap <= w_nop ? w_gap_inc : '0;
            case (r_state)
                CHK_WAIT, CHK_TRP, CHK_TRFC, CHK_TMRD: begin
                    if (!w_nop) begin
                        if (w_code != 3'd0) begin
                            r_state  <= CHK_FAIL;
                            err      <= 1'b1;
                            err_code <= w_code;
                        end else if (r_state == CHK_WAIT) begin
                            r_state <= CHK_TRP;
                        end else if (r_state == CHK_TRP) begin
                            r_state  <= CHK_TRFC;
                            r_ar_cnt <= 3'd1;
                        end else if (w_ar) begin
                            r_ar_cnt <= r_ar_cnt + 3'd1;
                        end else begin
                            r_state     <= CHK_TMRD;
                            mode_reg    <= addr_in;
                            cas_latency <= addr_in[6:4];
                            burst_len   <= addr_in[2:0];
                        end
                    end else if (r_state == CHK_TMRD && w_gap_inc >= L_TMRD) begin
                        r_state   <= CHK_DONE;
                        init_done <= 1'b1;
                    end
                end
                CHK_DONE: begin
                    if (w_lmr) begin
                        mode_reg    <= addr_in;
                        cas_latency <= addr_in[6:4];
                        burst_len   <= addr_in[2:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init_checker.sv
// Bench for sdram_init_checker: two instances (full and shortened power-up wait) on one bus,
// each compared every cycle against a step-table model, plus literal spot checks.
module tb_sdram_init_checker;

    localparam int TRP = 2, TRFC = 7, TMRD = 2, NAR = 2;
    localparam int INIT_BIG = 10000, INIT_SMALL = 20;
    localparam logic [3:0] C_NOP = 4'b0111, C_PRE = 4'b0010, C_AR = 4'b0001, C_LMR = 4'b0000;

    logic        sys_clk, sys_rst;
    logic [3:0]  cmd_in;
    logic [1:0]  ba_in;
    logic [12:0] addr_in;

    logic        d0_done, d1_done, d0_err, d1_err;
    logic [12:0] d0_mode, d1_mode;
    logic [2:0]  d0_cl, d1_cl, d0_bl, d1_bl, d0_code, d1_code;

    int n_checks = 0;
    int n_errors = 0;

    sdram_init_checker #(.INIT_WAIT_CLK(INIT_BIG), .TRP_CLK(TRP), .TRFC_CLK(TRFC),
                         .TMRD_CLK(TMRD), .AR_TIMES(NAR)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_in(cmd_in), .ba_in(ba_in),
        .addr_in(addr_in), .init_done(d0_done), .mode_reg(d0_mode), .cas_latency(d0_cl),
        .burst_len(d0_bl), .err(d0_err), .err_code(d0_code));

    sdram_init_checker #(.INIT_WAIT_CLK(INIT_SMALL), .TRP_CLK(TRP), .TRFC_CLK(TRFC),
                         .TMRD_CLK(TMRD), .AR_TIMES(NAR)) dut_s (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_in(cmd_in), .ba_in(ba_in),
        .addr_in(addr_in), .init_done(d1_done), .mode_reg(d1_mode), .cas_latency(d1_cl),
        .burst_len(d1_bl), .err(d1_err), .err_code(d1_code));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // model: the legal sequence is a list of steps (PRE, AR x NAR, LMR), each with a
    // required command, minimum preceding NOP gap and the code reported when too early
    typedef struct packed {
        int          step;
        int          gap;
        logic        done;
        logic        err;
        logic [2:0]  code;
        logic [12:0] mode;
    } m_t;

    m_t m0, m1;

    function automatic logic fields_ok(logic [12:0] a);
        logic [2:0] cl, bl;
        cl = a[6:4];
        bl = a[2:0];
        return (cl == 3'd2 || cl == 3'd3) && (bl <= 3'd3 || bl == 3'd7);
    endfunction

    function automatic m_t model_step(m_t s, logic [3:0] c, logic [12:0] a, int init_w);
        m_t n;
        logic nop;
        int lim;
        logic [2:0] tc, v;
        logic [3:0] want;
        n = s;
        nop = c[3] || (c[2:0] == 3'b111);
        n.gap = nop ? ((s.gap >= 65535) ? 65535 : s.gap + 1) : 0;
        if (s.err) return n;
        if (s.done) begin
            if (c == C_LMR) n.mode = a;
            return n;
        end
        want = C_NOP;
        if (s.step == NAR + 2) begin
            if (nop) begin
                if (s.gap + 1 >= TMRD) n.done = 1'b1;
                return n;
            end
            lim = TMRD; tc = 3'd5;
        end else begin
            if (nop) return n;
            if (s.step == 0) begin
                lim = init_w; tc = 3'd1; want = C_PRE;
            end else if (s.step == 1) begin
                lim = TRP; tc = 3'd3; want = C_AR;
            end else begin
                lim = TRFC; tc = 3'd4; want = (s.step <= NAR) ? C_AR : C_LMR;
            end
        end
        if (s.gap < lim)                      v = tc;
        else if (c == C_PRE && !a[10])        v = 3'd6;
        else if (c == C_LMR && !fields_ok(a)) v = 3'd7;
        else if (c != want)                   v = 3'd2;
        else                                  v = 3'd0;
        if (v != 3'd0) begin
            n.err = 1'b1;
            n.code = v;
        end else begin
            if (c == C_LMR) n.mode = a;
            n.step = s.step + 1;
        end
        return n;
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= model_step(m0, cmd_in, addr_in, INIT_BIG);
            m1 <= model_step(m1, cmd_in, addr_in, INIT_SMALL);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        check("big.init_done", 32'(d0_done), 32'(m0.done && !m0.err));
        check("big.mode_reg",  32'(d0_mode), 32'(m0.mode));
        check("big.cas_lat",   32'(d0_cl),   32'(m0.mode[6:4]));
        check("big.burst_len", 32'(d0_bl),   32'(m0.mode[2:0]));
        check("big.err",       32'(d0_err),  32'(m0.err));
        check("big.err_code",  32'(d0_code), 32'(m0.code));
        check("sml.init_done", 32'(d1_done), 32'(m1.done && !m1.err));
        check("sml.mode_reg",  32'(d1_mode), 32'(m1.mode));
        check("sml.cas_lat",   32'(d1_cl),   32'(m1.mode[6:4]));
        check("sml.burst_len", 32'(d1_bl),   32'(m1.mode[2:0]));
        check("sml.err",       32'(d1_err),  32'(m1.err));
        check("sml.err_code",  32'(d1_code), 32'(m1.code));
    end

    // one sampled bus cycle; returns 1 time unit after the edge that sampled it
    task automatic cyc(input logic [3:0] c, input logic [12:0] a);
        cmd_in = c;
        addr_in = a;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(C_NOP, 13'h0000);
    endtask

    task automatic reset_pulse();
        sys_rst = 1'b1;
        cmd_in = C_NOP;
        addr_in = '0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic nominal(input int init_w, input logic [12:0] lmr_a);
        nops(init_w);
        cyc(C_PRE, 13'h1FFF);
        nops(TRP);
        for (int i = 0; i < NAR; i++) begin
            cyc(C_AR, 13'h0000);
            nops(TRFC);
        end
        cyc(C_LMR, lmr_a);
        nops(TMRD);
    endtask

    initial begin
        ba_in = 2'b10;
        reset_pulse();
        check("reset.init_done", 32'(d0_done), 32'd0);
        check("reset.err_code",  32'(d0_code), 32'd0);

        nominal(INIT_BIG, 13'h0037);
        check("nom.init_done", 32'(d0_done), 32'd1);
        check("nom.mode_reg",  32'(d0_mode), 32'h0037);
        check("nom.cas_lat",   32'(d0_cl),   32'd3);
        check("nom.burst_len", 32'(d0_bl),   32'd7);
        check("nom.err",       32'(d0_err),  32'd0);

        reset_pulse();
        nops(INIT_BIG - 1);
        cyc(C_PRE, 13'h1FFF);
        check("early_pre.err",       32'(d0_err),  32'd1);
        check("early_pre.err_code",  32'(d0_code), 32'd1);
        check("early_pre.init_done", 32'(d0_done), 32'd0);

        reset_pulse();
        nops(INIT_SMALL);
        cyc(C_PRE, 13'h1FFF);
        nops(1);
        cyc(C_AR, 13'h0000);
        check("trp.err_code", 32'(d1_code), 32'd3);

        reset_pulse();
        nops(INIT_SMALL);
        cyc(C_PRE, 13'h0400);
        nops(TRP);
        cyc(C_AR, 13'h0000);
        nops(TRFC - 1);
        cyc(C_AR, 13'h0000);
        check("trfc.err_code", 32'(d1_code), 32'd4);

        reset_pulse();
        nops(INIT_SMALL);
        cyc(C_PRE, 13'h1FFF);
        nops(TRP);
        cyc(C_AR, 13'h0000);
        nops(TRFC);
        cyc(C_LMR, 13'h0037);
        check("few_ar.err_code", 32'(d1_code), 32'd2);
        check("few_ar.mode_reg", 32'(d1_mode), 32'h0000);

        reset_pulse();
        nops(INIT_SMALL);
        cyc(C_PRE, 13'h0000);
        check("pre_bank.err_code", 32'(d1_code), 32'd6);

        reset_pulse();
        nominal(INIT_SMALL, 13'h0017);
        check("bad_cl.err_code",  32'(d1_code), 32'd7);
        check("bad_cl.mode_reg",  32'(d1_mode), 32'h0000);
        check("bad_cl.init_done", 32'(d1_done), 32'd0);

        reset_pulse();
        nominal(INIT_SMALL, 13'h0023);
        check("sml_nom.init_done", 32'(d1_done), 32'd1);
        check("sml_nom.burst_len", 32'(d1_bl),   32'd3);
        cyc(C_LMR, 13'h0032);
        check("done_lmr.mode_reg", 32'(d1_mode), 32'h0032);
        check("done_lmr.err",      32'(d1_err),  32'd0);
        sys_rst = 1'b1;
        #1;
        check("rst_done.init_done", 32'(d1_done), 32'd0);
        check("rst_done.mode_reg",  32'(d1_mode), 32'h0000);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        nops(INIT_BIG);
        cyc(C_PRE, 13'h1FFF);
        nops(TRP);
        cyc(C_AR, 13'h0000);
        nops(3);
        sys_rst = 1'b1;
        #1;
        check("rst_trfc.err",       32'(d0_err),  32'd0);
        check("rst_trfc.err_code",  32'(d0_code), 32'd0);
        check("rst_trfc.init_done", 32'(d0_done), 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        nominal(INIT_BIG, 13'h0037);
        check("after_rst.init_done", 32'(d0_done), 32'd1);
        check("after_rst.err",       32'(d0_err),  32'd0);
        check("after_rst.mode_reg",  32'(d0_mode), 32'h0037);

        @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
